// File: rtl/bird_pkg.sv
// Shared types and defaults for the Flappy Bird bird-motion logic.
// Imported by the bird FSM and its row decoder.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } bird_state_t;

  localparam int BIRD_ROWS      = 8;
  localparam int BIRD_START_ROW = 3;

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot vector, forced to all zeros when disabled.
// Used to light the bird's LED row.
module onehot_decoder #(
  parameter int WIDTH = 8
) (
  input  logic [$clog2(WIDTH)-1:0] index,
  input  logic                     en,
  output logic [WIDTH-1:0]         onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot = WIDTH'(1) << index;
  end

endmodule

// File: rtl/bird_motion.sv
// Bird row tracker: IDLE until first flap, then flap/gravity motion
// with accelerating fall, dies on pipe hit or optional floor impact.
import bird_pkg::*;

module bird_motion #(
  parameter int ROWS        = BIRD_ROWS,
  parameter int START_ROW   = BIRD_START_ROW,
  parameter int FLAP_STEP   = 1,
  parameter int MAX_FALL    = 1,
  parameter int FLOOR_KILLS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flap,
  input  logic                          fall_tick,
  input  logic                          hit,
  input  logic                          restart,
  output logic [ROWS-1:0]               row_onehot,
  output logic [$clog2(ROWS)-1:0]       pos,
  output logic [$clog2(MAX_FALL+1)-1:0] vel,
  output logic                          bird_dead
);

  localparam int PW = $clog2(ROWS);
  localparam int VW = $clog2(MAX_FALL + 1);

  localparam logic [PW:0]   TOP_ROW = (PW+1)'(ROWS - 1);
  localparam logic [PW:0]   STEP    = (PW+1)'(FLAP_STEP);
  localparam logic [PW-1:0] START   = PW'(START_ROW);
  localparam logic [VW:0]   VMAX    = (VW+1)'(MAX_FALL);
  localparam logic [VW-1:0] VONE    = VW'(1);

  if (ROWS < 2) begin : g_chk_rows
    $fatal(1, "bird_motion: ROWS must be >= 2");
  end
  if (START_ROW >= ROWS) begin : g_chk_start
    $fatal(1, "bird_motion: START_ROW must be < ROWS");
  end
  if (FLAP_STEP < 1) begin : g_chk_step
    $fatal(1, "bird_motion: FLAP_STEP must be >= 1");
  end
  if (MAX_FALL < 1 || MAX_FALL >= ROWS) begin : g_chk_fall
    $fatal(1, "bird_motion: need 1 <= MAX_FALL < ROWS");
  end

  bird_state_t   state, state_n;
  logic [PW-1:0] pos_q, pos_n;
  logic [VW-1:0] vel_q, vel_n;

  logic [PW:0]   up, dn, vel_w;
  logic [PW-1:0] up_sat;
  logic [VW:0]   vinc;
  logic [VW-1:0] vel_up;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pos_q <= START;
      vel_q <= VONE;
    end else begin
      state <= state_n;
      pos_q <= pos_n;
      vel_q <= vel_n;
    end
  end

  // Widened arithmetic so the climb and velocity bump cannot wrap.
  always_comb begin
    up     = {1'b0, pos_q} + STEP;
    up_sat = (up > TOP_ROW) ? TOP_ROW[PW-1:0] : up[PW-1:0];
    vel_w  = (PW+1)'(vel_q);
    dn     = {1'b0, pos_q} - vel_w;
    vinc   = {1'b0, vel_q} + (VW+1)'(1);
    vel_up = (vinc > VMAX) ? VMAX[VW-1:0] : vinc[VW-1:0];
  end

  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    vel_n   = vel_q;
    if (restart) begin
      state_n = IDLE;
      pos_n   = START;
      vel_n   = VONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (flap) begin
            state_n = FLY;
            pos_n   = up_sat;
            vel_n   = VONE;
          end
        end
        FLY: begin
          if (hit) begin
            state_n = DEAD;
          end else if (flap && fall_tick) begin
            vel_n = VONE;
          end else if (flap) begin
            pos_n = up_sat;
            vel_n = VONE;
          end else if (fall_tick) begin
            if ({1'b0, pos_q} >= vel_w) begin
              pos_n = dn[PW-1:0];
              vel_n = vel_up;
            end else if (FLOOR_KILLS != 0) begin
              state_n = DEAD;
              pos_n   = '0;
            end else begin
              pos_n = '0;
              vel_n = VONE;
            end
          end
        end
        DEAD: ;
        default: begin
          state_n = IDLE;
          pos_n   = START;
          vel_n   = VONE;
        end
      endcase
    end
  end

  onehot_decoder #(.WIDTH(ROWS)) u_dec (
    .index  (pos_q),
    .en     (state != DEAD),
    .onehot (row_onehot)
  );

  assign pos       = pos_q;
  assign vel       = vel_q;
  assign bird_dead = (state == DEAD);

endmodule
